// File: rtl/pixel_feature_buffer.sv
// Frame buffer between the n-pixel averager and the classifier: captures one frame, replays it as a valid/ready stream.
// Optional running pixel sum output is enabled by defining PIXEL_SUM_EN.
module pixel_feature_buffer #(
  parameter  int PIXEL_WIDTH = 8,
  parameter  int N_PIXELS    = 784,
  localparam int IDX_W       = $clog2(N_PIXELS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [PIXEL_WIDTH-1:0] in_pixel,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [PIXEL_WIDTH-1:0] out_pixel,
  output logic [IDX_W-1:0]       out_index,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
`ifdef PIXEL_SUM_EN
  output logic [PIXEL_WIDTH+IDX_W:0] pixel_sum,
`endif
  output logic                   overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, PREFETCH, STREAM} state_t;

  state_t                 state;
  logic [IDX_W-1:0]       wr_ptr;
  logic [IDX_W-1:0]       nxt_idx;
  logic [PIXEL_WIDTH-1:0] rd_data;
  logic [PIXEL_WIDTH-1:0] mem [N_PIXELS];
  logic                   wr_en;
  logic                   load;
  logic                   rd_en;
  logic [IDX_W-1:0]       rd_addr;

  assign busy  = (state != IDLE);
  assign wr_en = (state == CAPTURE) && in_valid && !start;
  assign load  = (state == STREAM) && (!out_valid || out_ready);

  // rd_data always holds the pixel at nxt_idx, one ahead of the output register,
  // so a handshake every cycle can be sustained without a read bubble.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state == PREFETCH) begin
      rd_en = 1'b1;
    end else if (load && !(out_valid && out_last) && nxt_idx != LAST_IDX) begin
      rd_en   = 1'b1;
      rd_addr = nxt_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_pixel;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wr_ptr    <= '0;
      nxt_idx   <= '0;
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
`ifdef PIXEL_SUM_EN
      pixel_sum <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (start) begin
        state     <= CAPTURE;
        wr_ptr    <= '0;
        nxt_idx   <= '0;
        out_valid <= 1'b0;
        out_pixel <= '0;
        out_index <= '0;
        out_last  <= 1'b0;
        overflow  <= 1'b0;
`ifdef PIXEL_SUM_EN
        pixel_sum <= '0;
`endif
      end else begin
        if (in_valid && state != CAPTURE) overflow <= 1'b1;
        case (state)
          IDLE: ;
          CAPTURE: begin
            if (in_valid) begin
`ifdef PIXEL_SUM_EN
              pixel_sum <= pixel_sum + (PIXEL_WIDTH+IDX_W+1)'(in_pixel);
`endif
              if (wr_ptr == LAST_IDX) begin
                wr_ptr <= '0;
                state  <= PREFETCH;
              end else begin
                wr_ptr <= wr_ptr + IDX_W'(1);
              end
            end
          end
          PREFETCH: begin
            nxt_idx <= '0;
            state   <= STREAM;
          end
          STREAM: begin
            if (load) begin
              if (out_valid && out_last) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                done      <= 1'b1;
                state     <= IDLE;
              end else begin
                out_valid <= 1'b1;
                out_pixel <= rd_data;
                out_index <= nxt_idx;
                out_last  <= (nxt_idx == LAST_IDX);
                if (nxt_idx != LAST_IDX) nxt_idx <= nxt_idx + IDX_W'(1);
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pixel_feature_buffer.sv
// Directed bench for pixel_feature_buffer (PIXEL_WIDTH=8, N_PIXELS=16); define PIXEL_SUM_EN to cover pixel_sum.
module tb_pixel_feature_buffer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixel;
  logic [3:0] out_index;
  logic       out_last;
  logic       busy;
  logic       done;
  logic       overflow;
`ifdef PIXEL_SUM_EN
  logic [12:0] pixel_sum;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       ready;
    logic       inv;
    logic [7:0] ipix;
    logic       v;
    logic [7:0] pix;
    logic [3:0] idx;
    logic       last;
    logic       done;
    logic       busy;
    logic       ovf;
  } vec_t;

  vec_t tab [64];
  int   n;

  pixel_feature_buffer #(.PIXEL_WIDTH(8), .N_PIXELS(16)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_pixel(in_pixel),
    .out_valid(out_valid), .out_ready(out_ready), .out_pixel(out_pixel),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done),
`ifdef PIXEL_SUM_EN
    .pixel_sum(pixel_sum),
`endif
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_pixels(input int count, input bit cmode, input logic [7:0] cval);
    for (int i = 0; i < count; i++) begin
      in_valid = 1'b1;
      in_pixel = cmode ? cval : 8'(3 * i);
      tick();
    end
    in_valid = 1'b0;
    in_pixel = '0;
  endtask

  // Expected per-cycle trace starting the cycle after the last capture write.
  task automatic build(input bit stall, input bit cmode, input logic [7:0] cval, input bit inject);
    vec_t r;
    int k, c;
    n = 0; k = 0; c = 0;
    r = '0; r.ready = 1'b1; r.busy = 1'b1;
    tab[n] = r; n++;
    if (inject) begin r.inv = 1'b1; r.ipix = 8'h7F; end
    tab[n] = r; n++;
    r.inv = 1'b0; r.ipix = '0; r.ovf = inject;
    while (k < 16) begin
      r.ready = stall ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      r.v = 1'b1;
      r.pix = cmode ? cval : 8'(3 * k);
      r.idx = 4'(k);
      r.last = (k == 15);
      tab[n] = r; n++;
      if (r.ready) k++;
      c++;
    end
    r.v = 1'b0; r.pix = '0; r.idx = '0; r.last = 1'b0; r.ready = 1'b1;
    r.done = 1'b1; r.busy = 1'b0;
    tab[n] = r; n++;
    r.done = 1'b0;
    tab[n] = r; n++;
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < n; i++) begin
      out_ready = tab[i].ready;
      in_valid  = tab[i].inv;
      in_pixel  = tab[i].ipix;
      @(negedge clk);
      chk($sformatf("%s[%0d].out_valid", nm, i), 32'(out_valid), 32'(tab[i].v));
      if (tab[i].v) begin
        chk($sformatf("%s[%0d].out_pixel", nm, i), 32'(out_pixel), 32'(tab[i].pix));
        chk($sformatf("%s[%0d].out_index", nm, i), 32'(out_index), 32'(tab[i].idx));
        chk($sformatf("%s[%0d].out_last", nm, i), 32'(out_last), 32'(tab[i].last));
      end
      chk($sformatf("%s[%0d].done", nm, i), 32'(done), 32'(tab[i].done));
      chk($sformatf("%s[%0d].busy", nm, i), 32'(busy), 32'(tab[i].busy));
      chk($sformatf("%s[%0d].overflow", nm, i), 32'(overflow), 32'(tab[i].ovf));
      tick();
    end
    in_valid  = 1'b0;
    in_pixel  = '0;
    out_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_pixel = '0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.done", 32'(done), 0);
    chk("rst.overflow", 32'(overflow), 0);
    chk("rst.out_index", 32'(out_index), 0);
    tick();
    reset = 1'b0;
    tick();

    // Full-rate stream of 0,3,..,45
    send_start();
    send_pixels(16, 1'b0, '0);
    build(1'b0, 1'b0, '0, 1'b0);
    run_table("full");

    // in_valid while IDLE sets sticky overflow
    in_valid = 1'b1; in_pixel = 8'h7F;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("idle_ovf.overflow", 32'(overflow), 1);
    chk("idle_ovf.busy", 32'(busy), 0);
    tick(); tick();
    @(negedge clk);
    chk("idle_ovf.sticky", 32'(overflow), 1);
    tick();

    // start with a same-cycle in_valid: clears overflow, pixel not captured
    start = 1'b1; in_valid = 1'b1; in_pixel = 8'h55;
    tick();
    start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("start_inv.overflow", 32'(overflow), 0);
    chk("start_inv.busy", 32'(busy), 1);
    tick();
    send_pixels(16, 1'b0, '0);
    build(1'b1, 1'b0, '0, 1'b1);
    run_table("stall");

    // Abort after 9 pixels, then a frame of 0xAA
    send_start();
    @(negedge clk);
    chk("abort.ovf_cleared", 32'(overflow), 0);
    tick();
    send_pixels(9, 1'b1, 8'h11);
    send_start();
    @(negedge clk);
    chk("abort.busy", 32'(busy), 1);
    chk("abort.out_valid", 32'(out_valid), 0);
    chk("abort.done", 32'(done), 0);
    tick();
    send_pixels(16, 1'b1, 8'hAA);
    build(1'b0, 1'b1, 8'hAA, 1'b0);
    run_table("abort");

    // Frame of 127, stalled in STREAM, then asynchronous reset
    send_start();
    send_pixels(16, 1'b1, 8'd127);
    @(negedge clk);
    chk("sum.prefetch_busy", 32'(busy), 1);
    chk("sum.prefetch_valid", 32'(out_valid), 0);
`ifdef PIXEL_SUM_EN
    chk("sum.prefetch_sum", 32'(pixel_sum), 2032);
`endif
    tick(); tick();
    @(negedge clk);
    chk("midrst.pre_valid", 32'(out_valid), 1);
    chk("midrst.pre_pixel", 32'(out_pixel), 127);
`ifdef PIXEL_SUM_EN
    chk("sum.stream_sum", 32'(pixel_sum), 2032);
`endif
    #2 reset = 1'b1;
    #1;
    chk("midrst.out_valid", 32'(out_valid), 0);
    chk("midrst.out_pixel", 32'(out_pixel), 0);
    chk("midrst.out_index", 32'(out_index), 0);
    chk("midrst.out_last", 32'(out_last), 0);
    chk("midrst.busy", 32'(busy), 0);
    chk("midrst.done", 32'(done), 0);
    chk("midrst.overflow", 32'(overflow), 0);
`ifdef PIXEL_SUM_EN
    chk("midrst.sum", 32'(pixel_sum), 0);
`endif
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk("postrst.busy", 32'(busy), 0);
    chk("postrst.out_valid", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
